// File: rtl/hamming_encoder_pipe.sv
// Streaming SECDED Hamming(16,11) encoder, two register stages on a valid/ready stream.
// Optional error injection on the output codeword when HAMMING_ERR_INJECT_EN is defined.
module hamming_encoder_pipe #(
    parameter int unsigned COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [10:0]        data_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [15:0]        code_out,
    output logic [COUNT_W-1:0] word_count
`ifdef HAMMING_ERR_INJECT_EN
    ,
    input  logic               inj_en,
    input  logic [15:0]        inj_mask
`endif
);

    localparam int unsigned DATA_W = 11;
    localparam int unsigned CODE_W = 16;

    logic              s1_valid;
    logic [DATA_W-1:0] s1_data;
    logic              s1_p1, s1_p2, s1_p4, s1_p8;
    logic              s2_valid;

    logic              in_hs_c;
    logic              out_hs_c;
    logic              s2_load_c;
    logic [CODE_W-2:0] cw_c;
    logic [CODE_W-1:0] inj_c;

    // Handshakes and pipeline advance; in_ready sees out_ready combinationally (no skid buffer)
    always_comb begin
        out_hs_c  = s2_valid & out_ready;
        s2_load_c = s1_valid & (~s2_valid | out_ready);
        in_ready  = ~s1_valid | s2_load_c;
        in_hs_c   = in_valid & in_ready;
    end

    // Codeword bits [15:1]: parity at powers of two, data in the remaining positions
    always_comb begin
        cw_c       = '0;
        cw_c[0]    = s1_p1;
        cw_c[1]    = s1_p2;
        cw_c[2]    = s1_data[0];
        cw_c[3]    = s1_p4;
        cw_c[6:4]  = s1_data[3:1];
        cw_c[7]    = s1_p8;
        cw_c[14:8] = s1_data[10:4];
    end

`ifdef HAMMING_ERR_INJECT_EN
    assign inj_c = inj_en ? inj_mask : '0;
`else
    assign inj_c = '0;
`endif

    // Stage 1: capture data and the four Hamming parity bits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_p1    <= 1'b0;
            s1_p2    <= 1'b0;
            s1_p4    <= 1'b0;
            s1_p8    <= 1'b0;
        end else if (in_hs_c) begin
            s1_valid <= 1'b1;
            s1_data  <= data_in;
            s1_p1    <= data_in[0] ^ data_in[1] ^ data_in[3] ^ data_in[4]
                      ^ data_in[6] ^ data_in[8] ^ data_in[10];
            s1_p2    <= data_in[0] ^ data_in[2] ^ data_in[3] ^ data_in[5]
                      ^ data_in[6] ^ data_in[9] ^ data_in[10];
            s1_p4    <= data_in[1] ^ data_in[2] ^ data_in[3] ^ data_in[7]
                      ^ data_in[8] ^ data_in[9] ^ data_in[10];
            s1_p8    <= ^data_in[10:4];
        end else if (s2_load_c) begin
            s1_valid <= 1'b0;
        end
    end

    // Stage 2: overall parity over clean bits, then optional injection mask
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            code_out <= '0;
        end else if (s2_load_c) begin
            s2_valid <= 1'b1;
            code_out <= {^cw_c, cw_c} ^ inj_c;
        end else if (out_hs_c) begin
            s2_valid <= 1'b0;
        end
    end

    assign out_valid = s2_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_count <= '0;
        end else if (out_hs_c) begin
            word_count <= word_count + COUNT_W'(1);
        end
    end

endmodule
